// File: rtl/usb_line_monitor.sv
// USB bus line-state monitor: detects bus reset (SE0), suspend (idle J) and resume (K while
// suspended). The thresholds are given in microseconds and converted to cycles for each speed mode.
module usb_line_monitor #(
    parameter int unsigned FS_CLK_KHZ = 48000,
    parameter int unsigned LS_CLK_KHZ = 6000,
    parameter int unsigned RESET_US   = 5,
    parameter int unsigned SUSPEND_US = 3000,
    parameter int unsigned RESUME_US  = 1
) (
    input  logic       clk,
    input  logic       reset_ni,
    input  logic       usb_full_speed,
    input  logic [1:0] line_state,
    output logic       bus_reset_o,
    output logic       bus_reset_pls_o,
    output logic       suspend_o,
    output logic       resume_o
);

    function automatic int unsigned cycles(input int unsigned khz, input int unsigned us);
        longint unsigned t;
        t = (longint'(khz) * longint'(us)) / 1000;
        return (t == 0) ? 1 : int'(t);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned TRstFs  = cycles(FS_CLK_KHZ, RESET_US);
    localparam int unsigned TRstLs  = cycles(LS_CLK_KHZ, RESET_US);
    localparam int unsigned TSuspFs = cycles(FS_CLK_KHZ, SUSPEND_US);
    localparam int unsigned TSuspLs = cycles(LS_CLK_KHZ, SUSPEND_US);
    localparam int unsigned TResFs  = cycles(FS_CLK_KHZ, RESUME_US);
    localparam int unsigned TResLs  = cycles(LS_CLK_KHZ, RESUME_US);
    localparam int unsigned TMax    = max2(max2(max2(TRstFs, TRstLs), max2(TSuspFs, TSuspLs)),
                                           max2(TResFs, TResLs));
    localparam int unsigned CW      = $clog2(TMax + 1);

    localparam logic [1:0] LsSe0 = 2'b00;
    localparam logic [1:0] LsJ   = 2'b01;
    localparam logic [1:0] LsK   = 2'b10;

    typedef enum logic [1:0] {StActive, StReset, StSuspend} state_e;

    state_e          state_q;
    logic [1:0]      line_q;
    logic            mode_q;
    logic            mode_vld_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [CW-1:0]   t_rst;
    logic [CW-1:0]   t_susp;
    logic [CW-1:0]   t_res;
    logic            mode_toggle;
    logic            det_rst;
    logic            det_susp;
    logic            det_res;

    // mode_vld_q keeps the first edge after reset from being mistaken for a mode toggle
    always_comb begin
        mode_toggle = mode_vld_q && (usb_full_speed != mode_q);
        if (mode_toggle) begin
            cnt_d = '0;
        end else if (line_state == line_q) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        end else begin
            cnt_d = CW'(1);
        end
    end

    always_comb begin
        t_rst    = usb_full_speed ? CW'(TRstFs)  : CW'(TRstLs);
        t_susp   = usb_full_speed ? CW'(TSuspFs) : CW'(TSuspLs);
        t_res    = usb_full_speed ? CW'(TResFs)  : CW'(TResLs);
        // Equality only: a held or saturated run never re-triggers
        det_rst  = (line_state == LsSe0) && (cnt_d == t_rst);
        det_susp = (line_state == LsJ)   && (cnt_d == t_susp);
        det_res  = (line_state == LsK)   && (cnt_d == t_res);
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q         <= StActive;
            line_q          <= LsSe0;
            mode_q          <= 1'b0;
            mode_vld_q      <= 1'b0;
            cnt_q           <= '0;
            bus_reset_o     <= 1'b0;
            bus_reset_pls_o <= 1'b0;
            suspend_o       <= 1'b0;
            resume_o        <= 1'b0;
        end else begin
            line_q          <= line_state;
            mode_q          <= usb_full_speed;
            mode_vld_q      <= 1'b1;
            cnt_q           <= cnt_d;
            bus_reset_pls_o <= 1'b0;
            resume_o        <= 1'b0;
            case (state_q)
                StActive: begin
                    if (det_rst) begin
                        state_q         <= StReset;
                        bus_reset_o     <= 1'b1;
                        bus_reset_pls_o <= 1'b1;
                    end else if (det_susp) begin
                        state_q   <= StSuspend;
                        suspend_o <= 1'b1;
                    end
                end
                StReset: begin
                    if (line_state != LsSe0) begin
                        state_q     <= StActive;
                        bus_reset_o <= 1'b0;
                    end
                end
                StSuspend: begin
                    if (det_res) begin
                        state_q   <= StActive;
                        suspend_o <= 1'b0;
                        resume_o  <= 1'b1;
                    end else if (det_rst) begin
                        state_q         <= StReset;
                        suspend_o       <= 1'b0;
                        bus_reset_o     <= 1'b1;
                        bus_reset_pls_o <= 1'b1;
                    end
                end
                default: state_q <= StActive;
            endcase
        end
    end

endmodule
